uart_recv: RTL

- Serial-to-parallel UART receiver, 8N1, LSB first; the receive-side counterpart of the team's uart_send transmitter.
- Consumes the asynchronous rxd line (a txd from uart_send, or an external pin).
- Delivers each byte as a one-cycle out_dat/out_flag strobe, using the same byte/flag convention as the uart_send input side.
- Flags framing errors.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 42 ++++
 rtl/uart_recv.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks (uart_recv, uart_send).
//   DATA_W               - payload width of one character
//   CLK_FREQ_DEF/BAUD_DEF - default sys_clk frequency and line rate
//   state_t              - 3-bit receiver state encoding
//   maj3()               - 2-of-3 majority used for bit decisions
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous input plus a
// falling-edge detector on the synchronized value. Flops reset to 1 so an
// idle-high line does not produce a false edge when reset is released.
//   sys_clk - system clock, rising edge
//   rst     - asynchronous reset, active-low
//   din     - asynchronous input
//   dout    - synchronized input
//   fall    - one-cycle pulse when dout goes 1 -> 0
module uart_rx_sync (
  input  logic sys_clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q, dly_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign dout = sync_q;
  assign fall = dly_q & ~sync_q;

endmodule

// File: rtl/uart_recv.sv
// uart_recv: UART receiver, 8N1 LSB first (8E1 when UART_RECV_PARITY_EN is
// defined). Each bit is decided by a 2-of-3 majority of samples taken around
// the bit centre; timing re-aligns only on the start edge.
//   sys_clk    - system clock, rising edge
//   rst        - asynchronous reset, active-low
//   rxd        - serial input, asynchronous, idle high
//   out_dat    - last correctly framed byte
//   out_flag   - one-cycle pulse, out_dat updated
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse with out_flag on even-parity mismatch
//                (constant 0 without UART_RECV_PARITY_EN)
//   busy       - high from start-bit detection until back in IDLE
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | validating start bit; a high majority means glitch
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the even-parity bit (UART_RECV_PARITY_EN only)
// STOP   | checking stop bit; leaves at the decision point, mid-bit
// BREAK  | stop bit was low, wait for the line to return high
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF,
  parameter int BIT_CLKS = CLK_FREQ / BAUD
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_flag,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int H     = BIT_CLKS / 2;
  localparam int CNT_W = $clog2(BIT_CLKS);

  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(H + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

  logic rxd_s, rxd_fall;

  uart_rx_sync u_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .din     (rxd),
    .dout    (rxd_s),
    .fall    (rxd_fall)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              s0_q, s0_d;
  logic              s1_q, s1_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic              out_flag_q, out_flag_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
`ifdef UART_RECV_PARITY_EN
  logic              par_q, par_d;
  logic              parity_err_q, parity_err_d;
`endif

  logic maj, decide, wrap;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    out_dat_d   = out_dat_q;
    out_flag_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;
`ifdef UART_RECV_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    // Samples at H-1 and H are held so the vote at H+1 can use the live sample.
    maj    = maj3(s0_q, s1_q, rxd_s);
    decide = (cnt_q == CNT_DEC);
    wrap   = (cnt_q == CNT_LAST);

    if (state_q != ST_IDLE && state_q != ST_BREAK) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_S0) s0_d = rxd_s;
      if (cnt_q == CNT_S1) s1_d = rxd_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (rxd_fall) begin
          state_d = ST_START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (wrap) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (decide) shift_d[idx_q] = maj;
        if (wrap) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RECV_PARITY_EN
      ST_PARITY: begin
        if (decide) par_d = maj;
        if (wrap) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (decide) begin
          if (maj) begin
            out_dat_d  = shift_q;
            out_flag_d = 1'b1;
`ifdef UART_RECV_PARITY_EN
            parity_err_d = ^{shift_q, par_q};
`endif
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      out_dat_q   <= '0;
      out_flag_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      out_dat_q   <= out_dat_d;
      out_flag_q  <= out_flag_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef UART_RECV_PARITY_EN
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out_dat   = out_dat_q;
  assign out_flag  = out_flag_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
